rotary_step_counter: RTL



---
 rtl/rotary_pkg.sv | 12 +
 rtl/rotary_edge_dir.sv | 31 +++
 rtl/rotary_step_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared encodings for the rotary step counter: detent direction and lockout FSM states.
package rotary_pkg;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rotary_edge_dir.sv
// Registers the filtered rotation level and the B line, flags rising edges of the
// rotation level and decodes the detent direction from B as it stood one cycle earlier.
module rotary_edge_dir
  import rotary_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rotation_event,
  input  logic ROT_B,
  output logic rise,
  output logic dir_now
);

  logic ev_q;
  logic b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_q <= 1'b0;
      b_q  <= 1'b0;
    end else begin
      ev_q <= rotation_event;
      b_q  <= ROT_B;
    end
  end

  assign rise    = rotation_event & ~ev_q;
  // B low at the rising edge means clockwise.
  assign dir_now = b_q ? DIR_DEC : DIR_INC;

endmodule

// File: rtl/rotary_step_counter.sv
// Turns each accepted rotation detent into a +/-1 step of a wrapping or saturating
// accumulator, with a short lockout after every accepted detent.
module rotary_step_counter
  import rotary_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int WRAP    = 1,
  parameter int LOCKOUT = 4,
  parameter int INIT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rotation_event,
  input  logic             ROT_B,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir
);

  localparam int              CW        = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [CW-1:0]   LOCK_LOAD = CW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);
  localparam logic [WIDTH-1:0] MAX_V    = '1;
  localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT);

  logic             rise;
  logic             dir_now;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] value_n;
  logic [WIDTH-1:0] stepped;
  logic             step_n;
  logic             dir_n;
  logic             accept;

  rotary_edge_dir u_edge_dir (
    .clk            (clk),
    .reset          (reset),
    .rotation_event (rotation_event),
    .ROT_B          (ROT_B),
    .rise           (rise),
    .dir_now        (dir_now)
  );

  // Candidate next value for a step in the freshly decoded direction.
  always_comb begin
    stepped = value;
    if (dir_now == DIR_INC) begin
      if (value == MAX_V) stepped = (WRAP != 0) ? '0 : MAX_V;
      else                stepped = value + WIDTH'(1);
    end else begin
      if (value == '0)    stepped = (WRAP != 0) ? MAX_V : '0;
      else                stepped = value - WIDTH'(1);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    step_n  = 1'b0;
    dir_n   = dir;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          accept = 1'b1;
          step_n = 1'b1;
          dir_n  = dir_now;
          if (LOCKOUT > 0) begin
            state_n = HOLD;
            cnt_n   = LOCK_LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // clear only overrides the value; step, dir and the lockout proceed regardless.
  always_comb begin
    value_n = value;
    if (accept && enable) value_n = stepped;
    if (clear)            value_n = INIT_V;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      value <= INIT_V;
      step  <= 1'b0;
      dir   <= DIR_INC;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      value <= value_n;
      step  <= step_n;
      dir   <= dir_n;
    end
  end

endmodule
